// File: rtl/instruction_loader.sv
// Program loader: assembles big-endian UART bytes into instruction words and writes them
// into instruction memory until a HALT word, a full memory, or a mid-word byte timeout.
module instruction_loader #(
    parameter int unsigned      NBITS          = 32,
    parameter int unsigned      MEM_WORDS      = 256,
    parameter logic [NBITS-1:0] HALT_WORD      = 32'hFFFF_FFFF,
    parameter int unsigned      TIMEOUT_CYCLES = 100000
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_start,
    input  logic [7:0]                       i_rx_byte,
    input  logic                             i_rx_valid,
    output logic                             o_inst_mem_wr_en,
    output logic [NBITS-1:0]                 o_inst_mem_data,
    output logic [NBITS-1:0]                 o_inst_mem_addr,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_error,
    output logic [$clog2(MEM_WORDS+1)-1:0]   o_word_count
);

    localparam int unsigned WCW = $clog2(MEM_WORDS + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned PW  = NBITS - 8;

    localparam logic [WCW-1:0] WC_MAX     = WCW'(MEM_WORDS);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t           state_r, state_s;
    logic [1:0]       byte_cnt_r, byte_cnt_s;
    logic [PW-1:0]    partial_r, partial_s;
    logic [TW-1:0]    timer_r, timer_s;
    logic [WCW-1:0]   word_count_r, word_count_s;
    logic [WCW-1:0]   count_inc_s;
    logic [NBITS-1:0] data_r, data_s;
    logic [NBITS-1:0] addr_r, addr_s;
    logic [NBITS-1:0] word_s;
    logic             wr_en_r, wr_en_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             error_r, error_s;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_s      = state_r;
        byte_cnt_s   = byte_cnt_r;
        partial_s    = partial_r;
        timer_s      = timer_r;
        word_count_s = word_count_r;
        data_s       = data_r;
        addr_s       = {NBITS{1'b0}};
        wr_en_s      = 1'b0;
        word_s       = {partial_r, i_rx_byte};
        count_inc_s  = (word_count_r < WC_MAX) ? (word_count_r + WCW'(1)) : word_count_r;

        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    state_s      = ST_LOAD;
                    word_count_s = {WCW{1'b0}};
                    byte_cnt_s   = 2'd0;
                    timer_s      = {TW{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (i_rx_valid) begin
                    timer_s = {TW{1'b0}};
                    if (byte_cnt_r == 2'd3) begin
                        state_s    = ST_WRITE;
                        wr_en_s    = 1'b1;
                        data_s     = word_s;
                        addr_s     = NBITS'({word_count_r, 2'b00});
                        byte_cnt_s = 2'd0;
                    end else begin
                        partial_s  = word_s[PW-1:0];
                        byte_cnt_s = byte_cnt_r + 2'd1;
                    end
                end else if (byte_cnt_r != 2'd0) begin
                    // Only a partially assembled word can time out
                    if (timer_r >= TIMER_LAST) begin
                        state_s    = ST_ERROR;
                        byte_cnt_s = 2'd0;
                        timer_s    = {TW{1'b0}};
                    end else begin
                        timer_s = timer_r + TW'(1);
                    end
                end else begin
                    timer_s = {TW{1'b0}};
                end
            end
            ST_WRITE: begin
                word_count_s = count_inc_s;
                timer_s      = {TW{1'b0}};
                if ((data_r == HALT_WORD) || (count_inc_s == WC_MAX)) begin
                    state_s    = ST_DONE;
                    byte_cnt_s = 2'd0;
                end else begin
                    state_s = ST_LOAD;
                    // A byte landing in the write cycle starts the next word
                    if (i_rx_valid) begin
                        partial_s  = word_s[PW-1:0];
                        byte_cnt_s = 2'd1;
                    end else begin
                        byte_cnt_s = 2'd0;
                    end
                end
            end
            default: begin
                state_s    = ST_IDLE;
                byte_cnt_s = 2'd0;
                timer_s    = {TW{1'b0}};
            end
        endcase

        busy_s  = (state_s == ST_LOAD) || (state_s == ST_WRITE);
        done_s  = (state_s == ST_DONE);
        error_s = (state_s == ST_ERROR);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r      <= ST_IDLE;
            byte_cnt_r   <= 2'd0;
            partial_r    <= {PW{1'b0}};
            timer_r      <= {TW{1'b0}};
            word_count_r <= {WCW{1'b0}};
            data_r       <= {NBITS{1'b0}};
            addr_r       <= {NBITS{1'b0}};
            wr_en_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            state_r      <= state_s;
            byte_cnt_r   <= byte_cnt_s;
            partial_r    <= partial_s;
            timer_r      <= timer_s;
            word_count_r <= word_count_s;
            data_r       <= data_s;
            addr_r       <= addr_s;
            wr_en_r      <= wr_en_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            error_r      <= error_s;
        end
    end

    assign o_inst_mem_wr_en = wr_en_r;
    assign o_inst_mem_data  = data_r;
    assign o_inst_mem_addr  = addr_r;
    assign o_busy           = busy_r;
    assign o_done           = done_r;
    assign o_error          = error_r;
    assign o_word_count     = word_count_r;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with a small memory (4 words) and a short
// byte timeout (10 cycles) so the full-memory and timeout paths are reachable.
module tb_instruction_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        wr_en;
    logic [31:0] mem_data;
    logic [31:0] mem_addr;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  word_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    instruction_loader #(
        .NBITS          (32),
        .MEM_WORDS      (4),
        .HALT_WORD      (32'hFFFF_FFFF),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst_n),
        .i_start          (start),
        .i_rx_byte        (rx_byte),
        .i_rx_valid       (rx_valid),
        .o_inst_mem_wr_en (wr_en),
        .o_inst_mem_data  (mem_data),
        .o_inst_mem_addr  (mem_addr),
        .o_busy           (busy),
        .o_done           (done),
        .o_error          (error),
        .o_word_count     (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-port monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_data);
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[31:24]);
        send_byte(w[23:16]);
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_write(input int idx, input logic [31:0] exp_addr, input logic [31:0] exp_data);
        total++;
        if (wr_addr_q.size() <= idx) begin
            bad++;
            $display("FAIL write%0d_present: got %0d writes, want more than %0d", idx, wr_addr_q.size(), idx);
        end else begin
            if (wr_addr_q[idx] !== exp_addr) begin
                bad++;
                $display("FAIL write%0d_addr: got %h want %h", idx, wr_addr_q[idx], exp_addr);
            end
            total++;
            if (wr_data_q[idx] !== exp_data) begin
                bad++;
                $display("FAIL write%0d_data: got %h want %h", idx, wr_data_q[idx], exp_data);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if ({wr_en, busy, done, error, word_count, mem_addr, mem_data} !== 41'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b cnt=%0d addr=%h data=%h want all 0",
                     wr_en, busy, done, error, word_count, mem_addr, mem_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Now reset again in the middle of a write cycle
        pulse_start();
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        @(negedge clk);
        rx_byte  = 8'h78;
        rx_valid = 1'b1;
        @(posedge clk);
        #2;
        rx_valid = 1'b0;
        total++;
        if (wr_en !== 1'b1 || mem_data !== 32'h1234_5678) begin
            bad++;
            $display("FAIL pre_reset_write: got wr_en=%b data=%h want 1 12345678", wr_en, mem_data);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({wr_en, busy, done, error, word_count, mem_addr, mem_data} !== 41'd0) begin
            bad++;
            $display("FAIL async_reset_outputs: got %b/%b/%b/%b cnt=%0d addr=%h data=%h want all 0",
                     wr_en, busy, done, error, word_count, mem_addr, mem_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic test_single_word();
        pulse_start();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL start_busy: got %b want 1", busy);
        end
        send_word(32'h2408_0005);
        idle(2);
        total++;
        if (wr_addr_q.size() != 1) begin
            bad++;
            $display("FAIL single_write_count: got %0d want 1", wr_addr_q.size());
        end
        check_write(0, 32'h0000_0000, 32'h2408_0005);
        total++;
        if (word_count !== 3'd1 || busy !== 1'b1 || mem_addr !== 32'd0) begin
            bad++;
            $display("FAIL single_status: got cnt=%0d busy=%b addr=%h want 1 1 0", word_count, busy, mem_addr);
        end
    endtask

    task automatic test_halt();
        wr_addr_q.delete();
        wr_data_q.delete();
        idle(11);
        pulse_start();
        total++;
        if (word_count !== 3'd1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start_ignored_in_load: got cnt=%0d busy=%b want 1 1", word_count, busy);
        end
        send_word(32'h1122_3344);
        send_word(32'hFFFF_FFFF);
        idle(2);
        check_write(0, 32'h0000_0004, 32'h1122_3344);
        check_write(1, 32'h0000_0008, 32'hFFFF_FFFF);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || word_count !== 3'd3) begin
            bad++;
            $display("FAIL halt_status: got done=%b busy=%b cnt=%0d want 1 0 3", done, busy, word_count);
        end
        send_word(32'hCAFE_BABE);
        idle(2);
        total++;
        if (wr_addr_q.size() != 2 || done !== 1'b1) begin
            bad++;
            $display("FAIL halt_no_more_writes: got writes=%0d done=%b want 2 1", wr_addr_q.size(), done);
        end
    endtask

    task automatic test_mem_full();
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        total++;
        if (word_count !== 3'd0 || done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL restart_clears: got cnt=%0d done=%b busy=%b want 0 0 1", word_count, done, busy);
        end
        for (int i = 0; i < 4; i++) send_word(32'hA0B0_C0D0 + 32'(i));
        idle(2);
        for (int i = 0; i < 4; i++) check_write(i, 32'(i * 4), 32'hA0B0_C0D0 + 32'(i));
        total++;
        if (done !== 1'b1 || word_count !== 3'd4 || busy !== 1'b0) begin
            bad++;
            $display("FAIL full_status: got done=%b cnt=%0d busy=%b want 1 4 0", done, word_count, busy);
        end
        send_word(32'h0102_0304);
        idle(2);
        total++;
        if (wr_addr_q.size() != 4 || word_count !== 3'd4) begin
            bad++;
            $display("FAIL full_fifth_word: got writes=%0d cnt=%0d want 4 4", wr_addr_q.size(), word_count);
        end
    endtask

    task automatic test_timeout();
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h99);
        send_byte(8'h88);
        idle(5);
        total++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_early: got error=%b busy=%b want 0 1", error, busy);
        end
        idle(7);
        total++;
        if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL timeout_error: got error=%b busy=%b done=%b want 1 0 0", error, busy, done);
        end
        total++;
        if (wr_addr_q.size() != 0 || word_count !== 3'd0 || mem_data !== 32'hA0B0_C0D3) begin
            bad++;
            $display("FAIL timeout_no_write: got writes=%0d cnt=%0d data=%h want 0 0 a0b0c0d3",
                     wr_addr_q.size(), word_count, mem_data);
        end
        pulse_start();
        idle(15);
        total++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL no_timeout_between_words: got error=%b busy=%b want 0 1", error, busy);
        end
        send_word(32'hDEAD_BEEF);
        idle(2);
        check_write(0, 32'h0000_0000, 32'hDEAD_BEEF);
        total++;
        if (word_count !== 3'd1) begin
            bad++;
            $display("FAIL timeout_recover_count: got %0d want 1", word_count);
        end
    endtask

    task automatic test_back_to_back();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        @(negedge clk);
        rx_byte  = 8'h04;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_byte  = 8'hAA;
        @(negedge clk);
        rx_valid = 1'b0;
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        idle(2);
        total++;
        if (wr_addr_q.size() != 2) begin
            bad++;
            $display("FAIL b2b_write_count: got %0d want 2", wr_addr_q.size());
        end
        check_write(0, 32'h0000_0000, 32'h0102_0304);
        check_write(1, 32'h0000_0004, 32'hAABB_CCDD);
        total++;
        if (word_count !== 3'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_status: got cnt=%0d busy=%b want 2 1", word_count, busy);
        end
    endtask

    initial begin
        start    = 1'b0;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        test_reset();
        test_single_word();
        test_halt();
        test_mem_full();
        test_timeout();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
